// File: rtl/sha256_pkg.sv
// Shared types and constants for the SHA-256 unpadder.
// Define SHA256_UNPAD_WIDE_SCAN_EN to scan 16 bits per cycle instead of 4.
package sha256_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StScan,
        StDone
    } unpad_state_e;

    localparam int unsigned BLOCK_W      = 512;
    localparam int unsigned MSG_REGION_W = 448;
    localparam int unsigned LEN_W        = 64;
    localparam int unsigned MAX_MSG_BITS = 447;
    localparam int unsigned MSG_LEN_W    = 9;

`ifdef SHA256_UNPAD_WIDE_SCAN_EN
    localparam int unsigned SCAN_CHUNK_W = 16;
`else
    localparam int unsigned SCAN_CHUNK_W = 4;
`endif

    localparam int unsigned NUM_CHUNKS  = MSG_REGION_W / SCAN_CHUNK_W;
    localparam int unsigned CHUNK_CNT_W = $clog2(NUM_CHUNKS);
    localparam int unsigned TZ_W        = $clog2(SCAN_CHUNK_W);

endpackage

// File: rtl/sha256_unpadder_if.sv
// Start/done handshake and data bus between the unpadder and its user.
interface sha256_unpadder_if;
    import sha256_pkg::*;

    logic [BLOCK_W-1:0]      paddedMsg;
    logic                    beginUnpad;
    logic [MAX_MSG_BITS-1:0] msgOut;
    logic [MSG_LEN_W-1:0]    msgLen;
    logic                    error;
    logic                    busy;
    logic                    done;

    modport master (
        output paddedMsg,
        output beginUnpad,
        input  msgOut,
        input  msgLen,
        input  error,
        input  busy,
        input  done
    );

    modport slave (
        input  paddedMsg,
        input  beginUnpad,
        output msgOut,
        output msgLen,
        output error,
        output busy,
        output done
    );

endinterface

// File: rtl/unpad_tz_enc.sv
// Lowest-set-bit encoder: idx_o is the position of the least significant 1 in bits_i.
module unpad_tz_enc #(
    parameter int unsigned Width = 4,
    parameter int unsigned IdxW  = $clog2(Width)
) (
    input  logic [Width-1:0] bits_i,
    output logic [IdxW-1:0]  idx_o,
    output logic             found_o
);

    // Scan from the top so the lowest set bit is the last one to win.
    always_comb begin
        idx_o   = '0;
        found_o = |bits_i;
        for (int i = int'(Width) - 1; i >= 0; i--) begin
            if (bits_i[i]) idx_o = IdxW'(i);
        end
    end

endmodule

// File: rtl/sha256_unpadder.sv
// SHA-256 unpadder: finds the padding marker by chunked scan from the low end of the
// message region, checks it against the length field and returns the message.
// Scan width is set by SHA256_UNPAD_WIDE_SCAN_EN (see sha256_pkg).
module sha256_unpadder
    import sha256_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    sha256_unpadder_if.slave   bus
);

    unpad_state_e            state_q, state_d;
    logic [MAX_MSG_BITS-1:0] blk_msg_q, blk_msg_d;
    logic [LEN_W-1:0]        len_fld_q, len_fld_d;
    logic [MSG_REGION_W-1:0] scan_q, scan_d;
    logic [CHUNK_CNT_W-1:0]  k_q, k_d;
    logic [MAX_MSG_BITS-1:0] msg_q, msg_d;
    logic [MSG_LEN_W-1:0]    len_q, len_d;
    logic                    err_q, err_d;

    logic [TZ_W-1:0]         tz_idx;
    logic                    tz_found;
    logic [MSG_LEN_W-1:0]    z_pos;
    logic [MSG_LEN_W-1:0]    len_calc;
    logic [MAX_MSG_BITS-1:0] keep_mask;
    logic                    len_ok;

    unpad_tz_enc #(
        .Width (SCAN_CHUNK_W),
        .IdxW  (TZ_W)
    ) u_tz_enc (
        .bits_i  (scan_q[SCAN_CHUNK_W-1:0]),
        .idx_o   (tz_idx),
        .found_o (tz_found)
    );

    // Marker position within the region, the implied length and the message keep-mask.
    always_comb begin
        z_pos     = MSG_LEN_W'(k_q) * MSG_LEN_W'(SCAN_CHUNK_W) + MSG_LEN_W'(tz_idx);
        len_calc  = MSG_LEN_W'(MAX_MSG_BITS) - z_pos;
        keep_mask = ~({MAX_MSG_BITS{1'b1}} >> len_calc);
        len_ok    = (len_fld_q == LEN_W'(len_calc));
    end

    // Next-state and result logic.
    always_comb begin
        state_d   = state_q;
        blk_msg_d = blk_msg_q;
        len_fld_d = len_fld_q;
        scan_d    = scan_q;
        k_d       = k_q;
        msg_d     = msg_q;
        len_d     = len_q;
        err_d     = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.beginUnpad) begin
                    blk_msg_d = bus.paddedMsg[BLOCK_W-1:LEN_W+1];
                    len_fld_d = bus.paddedMsg[LEN_W-1:0];
                    scan_d    = bus.paddedMsg[BLOCK_W-1:LEN_W];
                    k_d       = '0;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (tz_found) begin
                    state_d = StDone;
                    if (len_ok) begin
                        msg_d = blk_msg_q & keep_mask;
                        len_d = len_calc;
                        err_d = 1'b0;
                    end else begin
                        msg_d = '0;
                        len_d = '0;
                        err_d = 1'b1;
                    end
                end else if (k_q == CHUNK_CNT_W'(NUM_CHUNKS - 1)) begin
                    // Whole region is zero: no marker.
                    state_d = StDone;
                    msg_d   = '0;
                    len_d   = '0;
                    err_d   = 1'b1;
                end else begin
                    scan_d = scan_q >> SCAN_CHUNK_W;
                    k_d    = k_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            blk_msg_q <= '0;
            len_fld_q <= '0;
            scan_q    <= '0;
            k_q       <= '0;
            msg_q     <= '0;
            len_q     <= '0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            blk_msg_q <= blk_msg_d;
            len_fld_q <= len_fld_d;
            scan_q    <= scan_d;
            k_q       <= k_d;
            msg_q     <= msg_d;
            len_q     <= len_d;
            err_q     <= err_d;
        end
    end

    assign bus.msgOut = msg_q;
    assign bus.msgLen = len_q;
    assign bus.error  = err_q;
    assign bus.busy   = (state_q != StIdle);
    assign bus.done   = (state_q == StDone);

endmodule

// File: tb/tb_sha256_unpadder.sv
// Self-checking bench for sha256_unpadder: directed blocks plus randomized blocks
// checked against a bit-level reference model of the unpadding rules.
module tb_sha256_unpadder;
    import sha256_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    sha256_unpadder_if bus ();

    sha256_unpadder dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: lowest set bit of [511:64] is the marker; everything else follows.
    function automatic void model(input logic [511:0] blk, output logic [446:0] m,
                                  output logic [8:0] l, output logic e, output int lat);
        int idx = -1;
        int z;
        int len;
        for (int i = 64; i < 512; i++) begin
            if (blk[i] && idx < 0) idx = i;
        end
        m = '0;
        l = '0;
        e = 1'b1;
        if (idx < 0) begin
            lat = 448 / int'(SCAN_CHUNK_W) + 1;
        end else begin
            z   = idx - 64;
            len = 447 - z;
            lat = z / int'(SCAN_CHUNK_W) + 2;
            if (blk[63:0] == 64'(len)) begin
                e = 1'b0;
                l = 9'(len);
                for (int j = 0; j < 447; j++) begin
                    if (j >= 447 - len) m[j] = blk[65 + j];
                end
            end
        end
    endfunction

    // Starts a run mid-cycle; optionally pokes beginUnpad or rst at a given scan cycle.
    task automatic do_run(input logic [511:0] blk, input int poke_cyc,
                          input logic [511:0] poke_blk, input int rst_cyc,
                          output int lat, output logic [446:0] m, output logic [8:0] l,
                          output logic e, output logic pulse_ok, output logic busy_ok);
        bus.paddedMsg  = blk;
        bus.beginUnpad = 1'b1;
        @(posedge clk);
        #1;
        bus.beginUnpad = 1'b0;
        lat      = -1;
        pulse_ok = 1'b1;
        busy_ok  = 1'b1;
        for (int cyc = 1; cyc <= 130; cyc++) begin
            if (rst_cyc < 0 && !bus.busy) busy_ok = 1'b0;
            if (bus.done) begin
                lat = cyc;
                break;
            end
            if (cyc == poke_cyc) begin
                bus.paddedMsg  = poke_blk;
                bus.beginUnpad = 1'b1;
            end
            if (cyc == rst_cyc) rst = 1'b1;
            @(posedge clk);
            #1;
            bus.beginUnpad = 1'b0;
            rst            = 1'b0;
        end
        m = bus.msgOut;
        l = bus.msgLen;
        e = bus.error;
        if (lat > 0) begin
            @(posedge clk);
            #1;
            pulse_ok = !bus.done;
        end
    endtask

    function automatic logic [511:0] abc_block(input int len_field);
        logic [511:0] b = '0;
        b[511:488] = 24'h616263;
        b[487]     = 1'b1;
        b[63:0]    = 64'(len_field);
        return b;
    endfunction

    task automatic test_reset();
        bus.paddedMsg  = '0;
        bus.beginUnpad = 1'b0;
        rst            = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        checks++;
        if (bus.msgOut !== '0) begin
            errors++;
            $display("FAIL reset_msgOut got=%h want=0", bus.msgOut);
        end
        checks++;
        if (bus.msgLen !== 9'd0) begin
            errors++;
            $display("FAIL reset_msgLen got=%0d want=0", bus.msgLen);
        end
        checks++;
        if ({bus.error, bus.busy, bus.done} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got err/busy/done=%b want=000",
                     {bus.error, bus.busy, bus.done});
        end
    endtask

    task automatic test_directed();
        logic [511:0] blks [5];
        int           want_lat [5];
        logic [446:0] em, gm;
        logic [8:0]   el, gl;
        logic         ee, ge, pulse_ok, busy_ok;
        int           elat, glat;
        logic [511:0] b;

        blks[0] = abc_block(24);
        b = '0;
        b[511] = 1'b1;
        blks[1] = b;
        b = '0;
        for (int i = 65; i < 512; i++) b[i] = ((511 - i) % 2 == 0);
        b[64]   = 1'b1;
        b[63:0] = 64'd447;
        blks[2] = b;
        blks[3] = abc_block(25);
        blks[4] = '0;
        if (SCAN_CHUNK_W == 4) want_lat = '{107, 113, 2, 107, 113};
        else                   want_lat = '{28, 29, 2, 28, 29};

        for (int t = 0; t < 5; t++) begin
            model(blks[t], em, el, ee, elat);
            do_run(blks[t], -1, '0, -1, glat, gm, gl, ge, pulse_ok, busy_ok);
            checks++;
            if (glat !== want_lat[t]) begin
                errors++;
                $display("FAIL directed%0d_latency got=%0d want=%0d", t, glat, want_lat[t]);
            end
            checks++;
            if (gm !== em) begin
                errors++;
                $display("FAIL directed%0d_msgOut got=%h want=%h", t, gm, em);
            end
            checks++;
            if (gl !== el || ge !== ee) begin
                errors++;
                $display("FAIL directed%0d_len_err got=%0d/%b want=%0d/%b", t, gl, ge, el, ee);
            end
            checks++;
            if (!pulse_ok || !busy_ok) begin
                errors++;
                $display("FAIL directed%0d_handshake got pulse_ok=%b busy_ok=%b want 1/1",
                         t, pulse_ok, busy_ok);
            end
            if (t == 0) begin
                checks++;
                if (gm[446:423] !== 24'h616263 || gl !== 9'd24) begin
                    errors++;
                    $display("FAIL abc_literal got=%h/%0d want=616263/24", gm[446:423], gl);
                end
            end
        end
    endtask

    task automatic test_rst_mid_scan();
        logic [446:0] em, gm;
        logic [8:0]   el, gl;
        logic         ee, ge, pulse_ok, busy_ok;
        int           elat, glat;
        do_run(abc_block(24), -1, '0, 50, glat, gm, gl, ge, pulse_ok, busy_ok);
        checks++;
        if (glat !== -1) begin
            errors++;
            $display("FAIL rst_mid_scan_no_done got done_cycle=%0d want none", glat);
        end
        checks++;
        if (gm !== '0 || gl !== 9'd0 || ge !== 1'b0 || bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid_scan_outputs got len=%0d err=%b busy=%b want 0/0/0",
                     gl, ge, bus.busy);
        end
        model(abc_block(24), em, el, ee, elat);
        do_run(abc_block(24), -1, '0, -1, glat, gm, gl, ge, pulse_ok, busy_ok);
        checks++;
        if (glat !== elat || gm !== em || gl !== el || ge !== ee) begin
            errors++;
            $display("FAIL rst_recover got lat=%0d len=%0d err=%b want lat=%0d len=%0d err=%b",
                     glat, gl, ge, elat, el, ee);
        end
    endtask

    task automatic test_ignore_begin();
        logic [446:0] em, gm;
        logic [8:0]   el, gl;
        logic         ee, ge, pulse_ok, busy_ok;
        int           elat, glat;
        logic [511:0] other = '0;
        other[64]   = 1'b1;
        other[63:0] = 64'd447;
        model(abc_block(24), em, el, ee, elat);
        do_run(abc_block(24), 10, other, -1, glat, gm, gl, ge, pulse_ok, busy_ok);
        checks++;
        if (glat !== elat || gm !== em || gl !== el || ge !== ee) begin
            errors++;
            $display("FAIL ignore_begin got lat=%0d len=%0d err=%b want lat=%0d len=%0d err=%b",
                     glat, gl, ge, elat, el, ee);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL ignore_begin_not_queued got busy=%b want 0", bus.busy);
        end
    endtask

    // Runs are issued back to back: each starts in the cycle right after the previous done.
    task automatic test_random();
        logic [446:0] em, gm;
        logic [8:0]   el, gl;
        logic         ee, ge, pulse_ok, busy_ok;
        int           elat, glat, len, mode;
        logic [511:0] b;
        for (int n = 0; n < 40; n++) begin
            mode = $urandom_range(0, 9);
            len  = (mode == 0) ? 0 : (mode == 1) ? 447 : $urandom_range(0, 447);
            b = '0;
            for (int i = 0; i < len; i++) b[511 - i] = 1'($urandom_range(0, 1));
            b[511 - len] = 1'b1;
            b[63:0]      = 64'(len);
            if (mode == 7) b[63:0] = b[63:0] ^ (64'd1 << $urandom_range(0, 63));
            if (mode == 8) b[511 - len] = 1'b0;
            if (mode == 9) for (int w = 0; w < 16; w++) b[w*32 +: 32] = $urandom;
            model(b, em, el, ee, elat);
            do_run(b, -1, '0, -1, glat, gm, gl, ge, pulse_ok, busy_ok);
            checks++;
            if (glat !== elat || gm !== em || gl !== el || ge !== ee || !pulse_ok || !busy_ok)
            begin
                errors++;
                $display("FAIL random%0d got lat=%0d len=%0d err=%b pulse=%b busy=%b msg=%h want lat=%0d len=%0d err=%b msg=%h",
                         n, glat, gl, ge, pulse_ok, busy_ok, gm, elat, el, ee, em);
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_rst_mid_scan();
        test_ignore_begin();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sha256_unpadder.md
# sha256_unpadder

Inverse of the SHA-256 message padder. Accepts one 512-bit padded block (message, single `1` marker bit, zero fill, 64-bit big-endian bit length), locates the marker by iterative scan, cross-checks it against the length field, and returns the original left-aligned message and its length, or flags a malformed block. Sits on the verification/loopback path beside the padder and shares its start/done pulse handshake.

## Interface
- No parameters; widths fixed by SHA-256 (see Structure).
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `paddedMsg`  in  512  padded block; [511:64] message region, [63:0] length field.
- `beginUnpad`  in  1  start request; sampled only in IDLE.
- `msgOut`  out  447  recovered message, MSB-first from bit 446; bits below the message are 0.
- `msgLen`  out  9  recovered length in bits, 0..447.
- `error`  out  1  block malformed; valid while `done`=1 and held afterwards.
- `busy`  out  1  high in SCAN and DONE.
- `done`  out  1  one-cycle pulse; results valid.

## Operation
- States: IDLE, SCAN, DONE.
- IDLE: on `beginUnpad`=1, capture `paddedMsg` into a block register, load the scan register with [511:64], clear chunk counter k, go to SCAN.
- SCAN: examine the low C bits of the scan register (C=4 by default).
  - Chunk nonzero: tz = index of its lowest set bit; z = C*k + tz; L = 447 − z; go to DONE.
  - Chunk zero and k < 448/C − 1: shift right by C, k++, stay.
  - Chunk zero and k = last: no marker; error; go to DONE.
- Validity: error = 1 if no marker, or if the length field ≠ L (this includes any nonzero bit in [63:9]).
- Result on success: `msgLen`=L; `msgOut` = captured [511:65] with bits [446−L:0] cleared.
- Result on error: `msgOut`=0, `msgLen`=0, `error`=1.
- DONE: `done`=1 for one cycle; return to IDLE unconditionally. Outputs hold until the next capture.
- `beginUnpad` in SCAN or DONE is ignored, not queued.

## Timing
- Reset: state IDLE; `msgOut`=0, `msgLen`=0, `error`=0, `busy`=0, `done`=0; internal registers cleared.
- Cycle 0 is the cycle with `beginUnpad`=1 in IDLE. SCAN examines chunk k in cycle k+1. `done` is high in cycle k+2, where k = ⌊z/C⌋.
- Latency, C=4: min 2 cycles (L=447), max 113 cycles (L=0 or no marker).
- A new `beginUnpad` is accepted in the cycle after `done` at the earliest.
- `rst` mid-SCAN: return to IDLE next edge; all outputs cleared; no `done`.
- `rst` and `beginUnpad` in the same cycle: reset wins.

## Configuration
- `SHA256_UNPAD_WIDE_SCAN_EN` defined: C=16, 28 chunks, max latency 29 cycles.
- Undefined: C=4, 112 chunks, max latency 113 cycles.
- Results, error rules and handshake are identical in both configurations; only the cycle at which `done` pulses changes.

## Structure
- Shared package `sha256_pkg` holds:
  - the state enum;
  - `MSG_REGION_W`=448, `LEN_W`=64, `MAX_MSG_BITS`=447, `BLOCK_W`=512;
  - `SCAN_CHUNK_W`, selected by the macro.
- One sub-module, `unpad_tz_enc`: combinational lowest-set-bit encoder over C bits, with outputs index and found.

## Test plan
- "abc" (0x616263 at [511:488], bit 487=1, length 24) -> C=4: `done` in cycle 107; C=16: cycle 28; `msgLen`=24, `msgOut`[446:423]=0x616263, rest 0, `error`=0.
- Empty message (bit 511=1, length 0) -> `done` in cycle 113 (C=16: 29); `msgLen`=0, `msgOut`=0, `error`=0.
- Full 447-bit message of alternating 1/0, bit 64=1, length 447 -> `done` in cycle 2; `msgOut`=[511:65]; `msgLen`=447.
- "abc" block with length field 25 -> `error`=1, `msgLen`=0, `msgOut`=0, `done` in cycle 107.
- Region all zeros, length 0 -> `error`=1, `done` in cycle 113 (C=16: 29).
- Assert `rst` in cycle 50 of an "abc" scan -> no `done`, outputs 0. Then `beginUnpad` with "abc" again -> normal result. A `beginUnpad` pulse during SCAN has no effect.
